sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-master arbiter and sequencer for the single 1K×32 masked SRAM. It shares the SRAM between the picorv32 native memory bus (m0) and the UART loader/debug port (m1), so memory can be reloaded or inspected while the core runs. Each granted request becomes exactly one SRAM read or masked write, followed by a one-cycle ready pulse to the owning master.

## Interface
Parameters:
- ADDR_BITS, 10, SRAM word-address width
- DATA_BITS, 32, word width; must be 32 (wstrb is 4 bits)

Ports:
- clk  in  1  system clock
- nRST  in  1  reset; asynchronous, active-low
- m0_valid  in  1  core request present (picorv32 mem_valid)
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_wstrb  in  4  byte strobes; 0 = read
- m0_ready  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid while m0_ready=1
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same set for the loader/debug master
- sram_rd_en  out  1  SRAM read enable
- sram_wr_en  out  1  SRAM write enable
- sram_addr  out  ADDR_BITS  word address
- sram_wdata  out  32  write data
- sram_mask  out  32  byte mask
- sram_rdata  in  32  SRAM data_out; valid one cycle after rd_en
- grant  out  1  owner of the current or last transaction (0=m0, 1=m1)

## Operation
States:
- IDLE: wait for a request.
  - If any valid=1: pick a winner, capture its addr/wdata/wstrb into registers, go to ACCESS.
  - Winner: a lone requester is always granted; on a tie the master opposite to `grant` wins (round-robin).
- ACCESS: the registered SRAM strobes are high for exactly this cycle; go to RDATA.
  - wstrb≠0: sram_wr_en=1.
  - wstrb=0: sram_rd_en=1.
- RDATA: on a read, latch sram_rdata into the owner's rdata register; go to DONE.
- DONE: owner's ready=1 for one cycle; return to IDLE.

Address and data rules:
- sram_addr = addr[ADDR_BITS+1:2]. addr[1:0] and the upper bits are ignored, so out-of-range addresses alias modulo 4 KiB.
- sram_mask: byte n = 8'hFF iff wstrb[n]=1. A read uses 32'hFFFFFFFF.
- sram_wdata = captured wdata, unmodified.
- Writes do not update rdata. A master's rdata holds its last read value until its next read.

Handshake and boundary cases:
- A request is committed once captured. If valid drops before ready, the access still executes and ready still pulses.
- The non-granted master's valid is held pending and served in the next IDLE. With both masters continuously requesting, grants alternate strictly.
- The owning master keeps valid high until ready (picorv32 behaviour). IDLE follows DONE, so a held valid is never re-accepted as a duplicate.
- wstrb values other than 0/1/2/4/8/3/12/15 still map bytewise; no error is raised.

Reset:
- nRST low: state=IDLE, grant=1 (so m0 wins the first tie).
- Outputs cleared: ready, rdata, all sram_* outputs, the capture registers.
- Reset asserted during ACCESS clears sram_wr_en asynchronously. The write is lost unless the clock edge was already taken.

## Timing
- valid sampled at edge 0 (IDLE).
- sram strobe high in cycle 1.
- SRAM data valid in cycle 2.
- ready high in cycle 3.
- Next acceptance at edge 4.
- Fixed latency 3 cycles valid→ready, for reads and writes alike. Peak throughput is 1 access per 4 cycles.
- All outputs come from registers; no combinational path from m*_valid to any output.
- Back-to-back from different masters: the second request's ACCESS cycle is 4 cycles after the first's.

## Structure
- Package sram_arb_pkg holds:
  - state enum {IDLE, ACCESS, RDATA, DONE}
  - WSTRB_READ/BYTE0..3/LOWER_HWORD/HIGHER_HWORD/WORD constants
  - function strb_to_mask(wstrb)
- No sub-module. The 2-way round-robin is a few lines inside the FSM. The existing masked SRAM is instantiated by the parent, not by this block.

## Test plan
- Reset, then m0 read of addr 0x0000_0010 with SRAM word 4 = 0xDEADBEEF → sram_rd_en high in cycle 1 with sram_addr=4; m0_ready in cycle 3 with m0_rdata=0xDEADBEEF; m1_ready stays 0.
- m1 write, wstrb=4'b0100, addr 0x8, wdata 0x00AB0000 → sram_wr_en for one cycle with addr=2, mask=0x00FF0000; m1_ready in cycle 3; m1_rdata unchanged.
- m0 and m1 valid in the same cycle after reset → m0 served first, m1 ACCESS 4 cycles later; grant sequence 0,1,0,1 under continuous requests.
- m0 read of addr 0x0000_1004 → sram_addr=1 (alias); m0_valid dropped after edge 0 → m0_ready still pulses in cycle 3.
- nRST asserted during ACCESS of a write → sram_wr_en falls immediately, state=IDLE, all ready/rdata = 0; the next request completes normally.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the two-master SRAM arbiter: FSM states, write-strobe encodings
// and the strobe-to-byte-mask helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic [3:0] WSTRB_READ         = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE0        = 4'b0001;
  localparam logic [3:0] WSTRB_BYTE1        = 4'b0010;
  localparam logic [3:0] WSTRB_BYTE2        = 4'b0100;
  localparam logic [3:0] WSTRB_BYTE3        = 4'b1000;
  localparam logic [3:0] WSTRB_LOWER_HWORD  = 4'b0011;
  localparam logic [3:0] WSTRB_HIGHER_HWORD = 4'b1100;
  localparam logic [3:0] WSTRB_WORD         = 4'b1111;

  // Reads enable every byte; any other strobe pattern maps bytewise, legal or not.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] wstrb);
    logic [31:0] mask;
    mask = '0;
    case (wstrb)
      WSTRB_READ,
      WSTRB_WORD:         mask = 32'hFFFF_FFFF;
      WSTRB_BYTE0:        mask = 32'h0000_00FF;
      WSTRB_BYTE1:        mask = 32'h0000_FF00;
      WSTRB_BYTE2:        mask = 32'h00FF_0000;
      WSTRB_BYTE3:        mask = 32'hFF00_0000;
      WSTRB_LOWER_HWORD:  mask = 32'h0000_FFFF;
      WSTRB_HIGHER_HWORD: mask = 32'hFFFF_0000;
      default: begin
        for (int n = 0; n < 4; n++) begin
          mask[8*n +: 8] = {8{wstrb[n]}};
        end
      end
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one masked SRAM between core (m0) and loader (m1).
// Fixed 3-cycle valid->ready, one access per 4 cycles; the losing master's valid simply waits.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 nRST,

  input  logic                 m0_valid,
  input  logic [31:0]          m0_addr,
  input  logic [DATA_BITS-1:0] m0_wdata,
  input  logic [3:0]           m0_wstrb,
  output logic                 m0_ready,
  output logic [DATA_BITS-1:0] m0_rdata,

  input  logic                 m1_valid,
  input  logic [31:0]          m1_addr,
  input  logic [DATA_BITS-1:0] m1_wdata,
  input  logic [3:0]           m1_wstrb,
  output logic                 m1_ready,
  output logic [DATA_BITS-1:0] m1_rdata,

  output logic                 sram_rd_en,
  output logic                 sram_wr_en,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_wdata,
  output logic [DATA_BITS-1:0] sram_mask,
  input  logic [DATA_BITS-1:0] sram_rdata,

  output logic                 grant
);

  arb_state_e           r_state;
  logic                 r_grant;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [3:0]           r_wstrb;
  logic [DATA_BITS-1:0] r_mask;
  logic                 r_rd_en;
  logic                 r_wr_en;
  logic                 r_m0_ready;
  logic                 r_m1_ready;
  logic [DATA_BITS-1:0] r_m0_rdata;
  logic [DATA_BITS-1:0] r_m1_rdata;

  logic                 w_pick;
  logic [31:0]          w_sel_addr;
  logic [DATA_BITS-1:0] w_sel_wdata;
  logic [3:0]           w_sel_wstrb;
  logic                 w_unused_addr_bits;

  // On a tie the master that did not own the last transaction wins.
  assign w_pick      = (m0_valid && m1_valid) ? ~r_grant : m1_valid;
  assign w_sel_addr  = w_pick ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_pick ? m1_wdata : m0_wdata;
  assign w_sel_wstrb = w_pick ? m1_wstrb : m0_wstrb;

  // Byte offset and bits above the SRAM window are dropped, so addresses alias.
  assign w_unused_addr_bits = ^{w_sel_addr[31:ADDR_BITS+2], w_sel_addr[1:0]};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_grant    <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_mask     <= '0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            r_grant <= w_pick;
            r_addr  <= w_sel_addr[ADDR_BITS+1:2];
            r_wdata <= w_sel_wdata;
            r_wstrb <= w_sel_wstrb;
            r_mask  <= strb_to_mask(w_sel_wstrb);
            r_wr_en <= (w_sel_wstrb != WSTRB_READ);
            r_rd_en <= (w_sel_wstrb == WSTRB_READ);
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
          r_state <= RDATA;
        end
        RDATA: begin
          if (r_wstrb == WSTRB_READ) begin
            if (r_grant) begin
              r_m1_rdata <= sram_rdata;
            end else begin
              r_m0_rdata <= sram_rdata;
            end
          end
          r_m0_ready <= ~r_grant;
          r_m1_ready <= r_grant;
          r_state    <= DONE;
        end
        DONE: begin
          // Returning through IDLE keeps a still-held valid from being taken twice.
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_ready   = r_m0_ready;
  assign m1_ready   = r_m1_ready;
  assign m0_rdata   = r_m0_rdata;
  assign m1_rdata   = r_m1_rdata;
  assign sram_rd_en = r_rd_en;
  assign sram_wr_en = r_wr_en;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_mask  = r_mask;
  assign grant      = r_grant;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised bench for sram_port_arbiter with a transaction-level reference model
// and a behavioural 1Kx32 masked SRAM.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_rd_en, sram_wr_en;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_mask;
  logic [31:0] sram_rdata = '0;
  logic        grant;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_BITS(10), .DATA_BITS(32)) dut (
    .clk(clk), .nRST(nRST),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_mask(sram_mask), .sram_rdata(sram_rdata),
    .grant(grant)
  );

  // Behavioural SRAM: masked write and registered read.
  logic [31:0] env_mem [1024];
  always @(posedge clk) begin
    if (sram_wr_en)
      for (int b = 0; b < 4; b++)
        if (sram_mask[8*b]) env_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    if (sram_rd_en) sram_rdata <= env_mem[sram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (s != 4'd0)
      for (int n = 0; n < 4; n++) m[8*n +: 8] = s[n] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Reference model state
  logic [31:0] ref_mem [1024];
  bit          mv[2], busy[2], drop[2], accepted[2], rand_on[2];
  logic [31:0] ma[2], md[2];
  logic [3:0]  ms[2];
  logic [31:0] exp_rd[2];
  bit          fl = 0;
  int          acc_e = -100;
  int          own = 0;
  int          last_own = 1;
  int          exp_grant = 1;
  logic [31:0] acc_addr, acc_data;
  logic [3:0]  acc_strb;
  int          rate = 60;
  int          gq[$];

  task automatic drive();
    m0_valid = mv[0]; m0_addr = ma[0]; m0_wdata = md[0]; m0_wstrb = ms[0];
    m1_valid = mv[1]; m1_addr = ma[1]; m1_wdata = md[1]; m1_wstrb = ms[1];
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit dr);
    mv[m] = 1; busy[m] = 1; accepted[m] = 0; drop[m] = dr;
    ma[m] = a; md[m] = d; ms[m] = s;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; busy[m] = 0; accepted[m] = 0; drop[m] = 0; exp_rd[m] = '0; rand_on[m] = 0;
    end
    fl = 0; acc_e = -100; last_own = 1; exp_grant = 1;
    drive();
  endtask

  task automatic step();
    logic [9:0] wa;
    int e, w;
    bit rdy;
    @(negedge clk);
    cyc++;
    wa = acc_addr[11:2];
    if (fl && cyc == acc_e) begin
      chk("rd_en", 32'(sram_rd_en), 32'(acc_strb == 4'd0));
      chk("wr_en", 32'(sram_wr_en), 32'(acc_strb != 4'd0));
      chk("sram_addr", 32'(sram_addr), 32'(wa));
      chk("sram_mask", sram_mask, exp_mask(acc_strb));
      if (acc_strb != 4'd0) chk("sram_wdata", sram_wdata, acc_data);
      gq.push_back(int'(grant));
    end else begin
      chk("rd_en_quiet", 32'(sram_rd_en), 32'd0);
      chk("wr_en_quiet", 32'(sram_wr_en), 32'd0);
    end
    if (fl && cyc == acc_e + 1 && acc_strb != 4'd0)
      for (int b = 0; b < 4; b++)
        if (acc_strb[b]) ref_mem[wa][8*b +: 8] = acc_data[8*b +: 8];
    if (fl && cyc == acc_e + 2 && acc_strb == 4'd0) exp_rd[own] = ref_mem[wa];
    rdy = fl && cyc == acc_e + 2;
    chk("m0_ready", 32'(m0_ready), 32'(rdy && own == 0));
    chk("m1_ready", 32'(m1_ready), 32'(rdy && own == 1));
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
    chk("grant", 32'(grant), 32'(exp_grant));
    if (rdy) begin busy[own] = 0; mv[own] = 0; end
    // Master behaviour: optional early drop after acceptance, random new requests.
    for (int m = 0; m < 2; m++) begin
      if (busy[m] && accepted[m] && drop[m]) mv[m] = 0;
      if (!busy[m] && rand_on[m] && $urandom_range(0, 99) < rate) begin
        issue(m, ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
              $urandom(), ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
              $urandom_range(0, 3) == 0);
      end
    end
    // Arbitration decision for the coming edge.
    e = cyc + 1;
    if ((!fl || e >= acc_e + 4) && (mv[0] || mv[1])) begin
      w = (mv[0] && mv[1]) ? 1 - last_own : (mv[1] ? 1 : 0);
      fl = 1; acc_e = e; own = w; last_own = w; exp_grant = w; accepted[w] = 1;
      acc_addr = ma[w]; acc_data = md[w]; acc_strb = ms[w];
    end
    drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
    chk({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, "_rd_en"}, 32'(sram_rd_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(sram_wr_en), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_mask"}, sram_mask, 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 0;
    model_reset();
    repeat (2) @(negedge clk);
    nRST = 1;
  endtask

  initial begin
    bit reached;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom();
      env_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    env_mem[4] = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    nRST = 1;

    // m0 read of word 4
    issue(0, 32'h0000_0010, 32'd0, 4'd0, 0);
    repeat (6) step();
    chk("tp1_rdata", m0_rdata, 32'hDEAD_BEEF);

    // m1 single-byte write
    issue(1, 32'h0000_0008, 32'h00AB_0000, 4'b0100, 0);
    repeat (6) step();
    chk("tp2_m1_rdata", m1_rdata, 32'd0);
    chk("tp2_sram_byte", env_mem[2] & 32'h00FF_0000, 32'h00AB_0000);

    // Simultaneous continuous requests from both masters
    do_reset();
    gq.delete();
    rand_on[0] = 1; rand_on[1] = 1; rate = 100;
    issue(0, 32'h40, 32'd0, 4'd0, 0);
    issue(1, 32'h44, 32'h1234_5678, 4'hF, 0);
    repeat (32) step();
    rand_on[0] = 0; rand_on[1] = 0;
    repeat (10) step();
    chk("tp3_count", 32'(gq.size() >= 4), 32'd1);
    if (gq.size() >= 4) begin
      chk("tp3_g0", 32'(gq[0]), 32'd0);
      chk("tp3_g1", 32'(gq[1]), 32'd1);
      chk("tp3_g2", 32'(gq[2]), 32'd0);
      chk("tp3_g3", 32'(gq[3]), 32'd1);
    end

    // Aliased address with valid dropped right after acceptance
    issue(0, 32'h0000_1004, 32'd0, 4'd0, 1);
    repeat (6) step();
    chk("tp4_rdata", m0_rdata, ref_mem[1]);

    // Reset asserted in the ACCESS cycle of a write
    issue(1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 0);
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      step();
      if (fl && cyc == acc_e) reached = 1;
    end
    chk("tp5_reached_access", 32'(reached), 32'd1);
    chk("tp5_wr_en_before", 32'(sram_wr_en), 32'd1);
    nRST = 0;
    #1;
    check_reset_outputs("tp5");
    model_reset();
    repeat (2) @(negedge clk);
    nRST = 1;
    chk("tp5_write_lost", env_mem[8], ref_mem[8]);
    issue(1, 32'h0000_0020, 32'd0, 4'd0, 0);
    repeat (6) step();
    chk("tp5_next_read", m1_rdata, ref_mem[8]);

    // Random traffic from both masters
    rand_on[0] = 1; rand_on[1] = 1; rate = 60;
    repeat (3000) step();
    rand_on[0] = 0; rand_on[1] = 0;
    repeat (12) step();
    chk("drain_idle", 32'(busy[0] || busy[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
